// File: rtl/jtkicker_cen_meter_pkg.sv
// Shared constants for the cen meter: FSM state encodings and saturation fills.
package jtkicker_cen_meter_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARM     = 2'd1;
   localparam logic [1:0] ST_MEASURE = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   // Wide all-ones source; count/gap registers slice their own saturation value from it
   localparam logic [31:0] SAT_ONES = '1;

endpackage

// File: rtl/jtkicker_cen_meter_if.sv
// Measurement request/result bundle between a controller and the cen meter.
interface jtkicker_cen_meter_if #(
   parameter int unsigned W  = 16,
   parameter int unsigned GW = 8
);
   logic          start;
   logic [W-1:0]  win;
   logic          busy;
   logic          done;
   logic [W-1:0]  count;
   logic [GW-1:0] min_gap;
   logic [GW-1:0] max_gap;
   logic          err_back;
   logic          timeout;

   modport master (
      output start, win,
      input  busy, done, count, min_gap, max_gap, err_back, timeout
   );

   modport slave (
      input  start, win,
      output busy, done, count, min_gap, max_gap, err_back, timeout
   );
endinterface

// File: rtl/jtkicker_cen_gap.sv
// Saturating cen-to-cen spacing counter with running min/max capture.
module jtkicker_cen_gap
   import jtkicker_cen_meter_pkg::*;
#(
   parameter int unsigned GW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          ref_hit,
   input  logic          tick,
   input  logic          cen,
   output logic [GW-1:0] min_gap,
   output logic [GW-1:0] max_gap
);

   localparam logic [GW-1:0] GAP_SAT = SAT_ONES[GW-1:0];

   // gcnt holds spacing minus one, so a cen on the very next cycle reads as a gap of 1
   logic [GW-1:0] gcnt;
   logic [GW-1:0] gap_cur;

   always_comb begin
      gap_cur = (gcnt == GAP_SAT) ? GAP_SAT : gcnt + GW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gcnt    <= '0;
         min_gap <= GAP_SAT;
         max_gap <= '0;
      end else begin
         if (clr) begin
            min_gap <= GAP_SAT;
            max_gap <= '0;
         end
         if (ref_hit) begin
            gcnt <= '0;
         end else if (tick) begin
            if (cen) begin
               if (gap_cur < min_gap) min_gap <= gap_cur;
               if (gap_cur > max_gap) max_gap <= gap_cur;
               gcnt <= '0;
            end else begin
               gcnt <= gap_cur;
            end
         end
      end
   end

endmodule

// File: rtl/jtkicker_cen_meter.sv
// Clock-enable stream monitor: counts cen pulses over a window after a reference
// pulse and reports spacing extremes, back-to-back errors and arm timeout.
module jtkicker_cen_meter
   import jtkicker_cen_meter_pkg::*;
#(
   parameter int unsigned W  = 16,
   parameter int unsigned GW = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cen,
   jtkicker_cen_meter_if.slave bus
);

   localparam logic [W-1:0]  CNT_SAT = SAT_ONES[W-1:0];
   localparam logic [GW-1:0] TMO_SAT = SAT_ONES[GW-1:0];

   logic [1:0]    st;
   logic [W-1:0]  wcnt;
   logic [GW-1:0] tcnt;
   logic          prev_cen;
   logic          busy_q, done_q, err_q, tmo_q;
   logic [W-1:0]  count_q;
   logic [GW-1:0] min_w, max_w;
   logic          accept, ref_hit, meas;

   assign accept  = (st == ST_IDLE) && bus.start;
   assign ref_hit = (st == ST_ARM) && cen;
   assign meas    = (st == ST_MEASURE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st       <= ST_IDLE;
         wcnt     <= '0;
         tcnt     <= '0;
         prev_cen <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         count_q  <= '0;
         err_q    <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         prev_cen <= cen;
         done_q   <= 1'b0;
         case (st)
            ST_IDLE: begin
               if (bus.start) begin
                  wcnt    <= bus.win;
                  tcnt    <= '0;
                  count_q <= '0;
                  err_q   <= 1'b0;
                  tmo_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  st      <= ST_ARM;
               end
            end
            ST_ARM: begin
               if (cen) begin
                  if (wcnt == '0) begin
                     st     <= ST_DONE;
                     done_q <= 1'b1;
                     busy_q <= 1'b0;
                  end else begin
                     st <= ST_MEASURE;
                  end
               end else if (tcnt == TMO_SAT) begin
                  tmo_q  <= 1'b1;
                  st     <= ST_DONE;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
               end else begin
                  tcnt <= tcnt + GW'(1);
               end
            end
            ST_MEASURE: begin
               if (cen) begin
                  if (count_q != CNT_SAT) count_q <= count_q + W'(1);
                  // prev_cen covers the reference pulse on the first measured cycle
                  if (prev_cen) err_q <= 1'b1;
               end
               if (wcnt == W'(1)) begin
                  st     <= ST_DONE;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
               end else begin
                  wcnt <= wcnt - W'(1);
               end
            end
            default: begin
               st <= ST_IDLE;
            end
         endcase
      end
   end

   jtkicker_cen_gap #(
      .GW(GW)
   ) u_gap (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (accept),
      .ref_hit (ref_hit),
      .tick    (meas),
      .cen     (cen),
      .min_gap (min_w),
      .max_gap (max_w)
   );

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.count    = count_q;
   assign bus.min_gap  = min_w;
   assign bus.max_gap  = max_w;
   assign bus.err_back = err_q;
   assign bus.timeout  = tmo_q;

endmodule

// File: tb/tb_jtkicker_cen_meter.sv
// Scoreboard bench for jtkicker_cen_meter: directed cen patterns with hand-derived results.
module tb_jtkicker_cen_meter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cen = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   jtkicker_cen_meter_if #(.W(16), .GW(8)) bus ();

   jtkicker_cen_meter #(
      .W (16),
      .GW(8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .cen  (cen),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cnt;
      int mn;
      int mx;
      int err;
      int tmo;
      int at;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Pattern index i is the cycle number after the start edge (0 = first ARM cycle)
   function automatic bit pat(input int kind, input int i);
      case (kind)
         0:       return (i % 4) == 3;
         1:       return ((i + 1) * 32) / 125 > (i * 32) / 125;
         3:       return ((i % 8) == 7) || (i == 24);
         4:       return (i % 4) == 1;
         default: return 1'b0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_cycle", cyc, e.at);
            check("busy_at_done", int'(bus.busy), 0);
            check("count", int'(bus.count), e.cnt);
            check("min_gap", int'(bus.min_gap), e.mn);
            check("max_gap", int'(bus.max_gap), e.mx);
            check("err_back", int'(bus.err_back), e.err);
            check("timeout", int'(bus.timeout), e.tmo);
         end
      end
   end

   // extra: 1 = competing start mid-run, 2 = start on the done cycle
   task automatic run(input int kind, input logic [15:0] w, input int e_cnt, input int e_min,
                      input int e_max, input int e_err, input int e_tmo, input int e_done,
                      input int extra, input bit abort);
      exp_t e;
      int   base;
      bus.start = 1'b1;
      bus.win   = w;
      cen       = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      base = cyc;
      if (!abort) begin
         e.cnt = e_cnt; e.mn = e_min; e.mx = e_max;
         e.err = e_err; e.tmo = e_tmo; e.at = base + e_done;
         sb.push_back(e);
      end
      for (int i = 0; i < e_done + 3; i++) begin
         cen = pat(kind, i);
         if (extra == 1 && i == 20) begin
            bus.start = 1'b1;
            bus.win   = 16'd5;
         end
         if (extra == 2 && i == e_done) bus.start = 1'b1;
         if (abort && i == 50) rst_n = 1'b0;
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         if (extra == 2 && i == e_done) check("start_on_done_ignored", int'(bus.busy), 0);
         if (abort && i == 50) begin
            check("abort_busy", int'(bus.busy), 0);
            check("abort_done", int'(bus.done), 0);
            check("abort_count", int'(bus.count), 0);
            check("abort_min", int'(bus.min_gap), 255);
            check("abort_max", int'(bus.max_gap), 0);
            check("abort_err", int'(bus.err_back), 0);
            check("abort_tmo", int'(bus.timeout), 0);
            rst_n = 1'b1;
            break;
         end
      end
      cen = 1'b0;
      if (!abort) begin
         check("hold_count", int'(bus.count), e_cnt);
         check("hold_min", int'(bus.min_gap), e_min);
         check("hold_busy", int'(bus.busy), 0);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.win   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_count", int'(bus.count), 0);
      check("rst_min", int'(bus.min_gap), 255);
      check("rst_max", int'(bus.max_gap), 0);
      check("rst_err", int'(bus.err_back), 0);
      check("rst_tmo", int'(bus.timeout), 0);
      rst_n = 1'b1;

      // 1/4 stream, ref at i=3, window 100 -> done at i=104, 25 pulses
      run(0, 16'd100, 25, 4, 4, 0, 0, 104, 1, 1'b0);
      // 32/125 stream, ref at i=3, pulses in i=4..1003 = 257-1
      run(1, 16'd1000, 256, 3, 4, 0, 0, 1004, 0, 1'b0);
      // stuck low: 256 ARM cycles then done
      run(2, 16'd10, 0, 255, 0, 0, 1, 256, 0, 1'b0);
      // 1/8 stream with extra pulse at i=24 right after i=23
      run(3, 16'd64, 9, 1, 8, 1, 0, 72, 0, 1'b0);
      // win=0: ref at i=1, done at i=2
      run(4, 16'd0, 0, 255, 0, 0, 0, 2, 2, 1'b0);
      // reset at measured cycle, then a normal run starting right after release
      run(0, 16'd100, 0, 0, 0, 0, 0, 104, 0, 1'b1);
      run(0, 16'd100, 25, 4, 4, 0, 0, 104, 0, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      while (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         check("missing_done", 0, 1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
